// File: rtl/hazard3_muldiv_iter.sv
// Iterative multiply/divide unit: signed operands are reduced to magnitudes around an unsigned
// shift-add / restoring-divide core. Optional macro HAZARD3_MULDIV_EARLY_EXIT_EN skips leading dividend zeros.
module hazard3_muldiv_iter #(
   parameter int XLEN   = 32,
   parameter int UNROLL = 1,
   parameter int W_TAG  = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [2:0]       op_i,
   input  logic             op_vld_i,
   output logic             op_rdy_o,
   input  logic             op_kill_i,
   input  logic [XLEN-1:0]  op_a_i,
   input  logic [XLEN-1:0]  op_b_i,
   input  logic [W_TAG-1:0] op_tag_i,
   output logic             result_vld_o,
   input  logic             result_rdy_i,
   output logic [XLEN-1:0]  result_o,
   output logic [W_TAG-1:0] result_tag_o
);
   localparam int NSTEP = XLEN / UNROLL;
   localparam int CW    = $clog2(NSTEP + 1);

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_PREADJ  = 3'd1,
      S_ITER    = 3'd2,
      S_POSTADJ = 3'd3,
      S_CARRY   = 3'd4,
      S_DONE    = 3'd5
   } state_t;

   state_t              state_q, state_d;
   logic [2*XLEN-1:0]   acc_q, acc_d, iter_acc, post_acc;
   logic [XLEN-1:0]     m_q, m_d, result_q, result_d;
   logic [CW-1:0]       cnt_q, cnt_d, cnt_load;
   logic [2:0]          op_q, op_d;
   logic [W_TAG-1:0]    tag_q, tag_d;
   logic                sa_q, sa_d, sb_q, sb_d;
   logic                accept, is_div, pre_sa, pre_sb, post_carry, neg;
   logic [XLEN-1:0]     a_raw, b_raw, a_mag, b_mag, div_lo, lo, hi;

   // One unrolled step; the accumulator holds {partial, operand} for both operations.
   function automatic logic [2*XLEN-1:0] step(input logic [2*XLEN-1:0] acc,
                                              input logic [XLEN-1:0] m, input logic div);
      logic [XLEN:0] sum;
      logic [XLEN:0] diff;
      sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, m} : {(XLEN+1){1'b0}});
      diff = acc[2*XLEN-1:XLEN-1] - {1'b0, m};
      if (!div)          step = {sum, acc[XLEN-1:1]};
      else if (diff[XLEN]) step = {acc[2*XLEN-2:0], 1'b0};
      else               step = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
   endfunction

   assign accept       = op_vld_i && (op_rdy_o || op_kill_i);
   assign result_o     = result_q;
   assign result_tag_o = tag_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (op_kill_i) begin
         state_d = accept ? S_PREADJ : S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:    if (accept) state_d = S_PREADJ;
            S_PREADJ:  state_d = (cnt_load == '0) ? S_POSTADJ : S_ITER;
            S_ITER:    if (cnt_q == CW'(1)) state_d = S_POSTADJ;
            S_POSTADJ: state_d = post_carry ? S_CARRY : S_DONE;
            S_CARRY:   state_d = S_DONE;
            S_DONE:    if (result_rdy_i) state_d = accept ? S_PREADJ : S_IDLE;
            default:   state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      op_rdy_o     = (state_q == S_IDLE) || ((state_q == S_DONE) && result_rdy_i);
      result_vld_o = (state_q == S_DONE);
   end

   // Operands sit in the accumulator as {b, a} between accept and PREADJ.
   always_comb begin
      a_raw  = acc_q[XLEN-1:0];
      b_raw  = acc_q[2*XLEN-1:XLEN];
      is_div = op_q[2];
      pre_sa = a_raw[XLEN-1] && (op_q == OP_MULH || op_q == OP_MULHSU || op_q == OP_DIV || op_q == OP_REM);
      pre_sb = b_raw[XLEN-1] && (op_q == OP_MULH || op_q == OP_DIV || op_q == OP_REM);
      a_mag  = pre_sa ? -a_raw : a_raw;
      b_mag  = pre_sb ? -b_raw : b_raw;
   end

`ifdef HAZARD3_MULDIV_EARLY_EXIT_EN
   localparam int KW = $clog2(XLEN + 1);
   logic [KW-1:0] lz, k;

   always_comb begin
      lz = KW'(XLEN);
      for (int i = 0; i < XLEN; i++) begin
         if (a_mag[i]) lz = KW'(XLEN - 1 - i);
      end
      k        = is_div ? KW'((int'(lz) / UNROLL) * UNROLL) : '0;
      div_lo   = a_mag << k;
      cnt_load = CW'((XLEN - int'(k)) / UNROLL);
   end
`else
   always_comb begin
      div_lo   = a_mag;
      cnt_load = CW'(NSTEP);
   end
`endif

   always_comb begin
      iter_acc = acc_q;
      for (int i = 0; i < UNROLL; i++) begin
         iter_acc = step(iter_acc, m_q, op_q[2]);
      end
   end

   always_comb begin
      lo         = acc_q[XLEN-1:0];
      hi         = acc_q[2*XLEN-1:XLEN];
      neg        = sa_q ^ sb_q;
      post_acc   = acc_q;
      post_carry = 1'b0;
      if (is_div) begin
         // A zero divisor leaves the all-ones quotient uncorrected.
         post_acc = {(sa_q ? -hi : hi), ((neg && (m_q != '0)) ? -lo : lo)};
      end else if (neg) begin
         post_acc   = {~hi, -lo};
         post_carry = (lo == '0);
      end
   end

   always_comb begin
      acc_d    = acc_q;
      m_d      = m_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      tag_d    = tag_q;
      sa_d     = sa_q;
      sb_d     = sb_q;
      result_d = result_q;
      if (accept) begin
         acc_d = {op_b_i, op_a_i};
         op_d  = op_i;
         tag_d = op_tag_i;
      end else begin
         case (state_q)
            S_PREADJ: begin
               sa_d  = pre_sa;
               sb_d  = pre_sb;
               cnt_d = cnt_load;
               acc_d = is_div ? {{XLEN{1'b0}}, div_lo} : {{XLEN{1'b0}}, b_mag};
               m_d   = is_div ? b_mag : a_mag;
            end
            S_ITER: begin
               acc_d = iter_acc;
               cnt_d = cnt_q - CW'(1);
            end
            S_POSTADJ: begin
               acc_d    = post_acc;
               result_d = (op_q == OP_MUL || op_q == OP_DIV || op_q == OP_DIVU) ?
                          post_acc[XLEN-1:0] : post_acc[2*XLEN-1:XLEN];
            end
            S_CARRY: begin
               acc_d    = {hi + XLEN'(1), lo};
               result_d = hi + XLEN'(1);
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q    <= '0;
         m_q      <= '0;
         cnt_q    <= '0;
         op_q     <= '0;
         tag_q    <= '0;
         sa_q     <= 1'b0;
         sb_q     <= 1'b0;
         result_q <= '0;
      end else begin
         acc_q    <= acc_d;
         m_q      <= m_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         tag_q    <= tag_d;
         sa_q     <= sa_d;
         sb_q     <= sb_d;
         result_q <= result_d;
      end
   end

endmodule

// File: tb/tb_hazard3_muldiv_iter.sv
// Self-checking bench for hazard3_muldiv_iter (XLEN=32, UNROLL=1) against an arithmetic reference model.
module tb_hazard3_muldiv_iter;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [2:0]  op = '0;
   logic        op_vld = 1'b0;
   logic        op_rdy;
   logic        op_kill = 1'b0;
   logic [31:0] op_a = '0;
   logic [31:0] op_b = '0;
   logic [4:0]  op_tag = '0;
   logic        result_vld;
   logic        result_rdy = 1'b1;
   logic [31:0] result;
   logic [4:0]  result_tag;

`ifdef HAZARD3_MULDIV_EARLY_EXIT_EN
   localparam bit EE = 1'b1;
`else
   localparam bit EE = 1'b0;
`endif

   hazard3_muldiv_iter #(.XLEN(32), .UNROLL(1), .W_TAG(5)) dut (
      .clk(clk), .rst_n(rst_n), .op_i(op), .op_vld_i(op_vld), .op_rdy_o(op_rdy),
      .op_kill_i(op_kill), .op_a_i(op_a), .op_b_i(op_b), .op_tag_i(op_tag),
      .result_vld_o(result_vld), .result_rdy_i(result_rdy), .result_o(result),
      .result_tag_o(result_tag)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  tag;
      int          due;
      int          lat;
   } exp_t;

   exp_t        q[$];
   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   int          pops = 0;
   logic [31:0] last_res = '0;
   logic [31:0] last_dut = '0;
   logic [4:0]  last_tag = '0;
   int          last_lat = 0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Reference: RISC-V M-extension arithmetic plus the latency rule.
   task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output int lat);
      logic [63:0]        p;
      logic               neg;
      logic signed [31:0] sa;
      logic signed [31:0] sb;
      p   = '0;
      neg = 1'b0;
      r   = '0;
      lat = 34;
      sa  = a;
      sb  = b;
      case (o)
         3'd0: begin p = {32'b0, a} * {32'b0, b}; r = p[31:0]; end
         3'd1: begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); r = p[63:32]; neg = a[31] ^ b[31]; end
         3'd2: begin p = $signed({{32{a[31]}}, a}) * $signed({32'b0, b}); r = p[63:32]; neg = a[31]; end
         3'd3: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
         3'd4: begin
            if (b == 0) r = 32'hFFFFFFFF;
            else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = a;
            else r = 32'(sa / sb);
         end
         3'd5: r = (b == 0) ? 32'hFFFFFFFF : a / b;
         3'd6: begin
            if (b == 0) r = a;
            else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h0;
            else r = 32'(sa % sb);
         end
         default: r = (b == 0) ? a : a % b;
      endcase
      if (!o[2] && neg && p[31:0] == 32'h0) lat = 35;
`ifdef HAZARD3_MULDIV_EARLY_EXIT_EN
      if (o[2]) begin
         logic [31:0] mag;
         int lz;
         mag = ((o == 3'd4 || o == 3'd6) && a[31]) ? -a : a;
         lz  = 32;
         for (int i = 0; i < 32; i++) if (mag[i]) lz = 31 - i;
         lat = 2 + 32 - lz;
      end
`endif
   endtask

   // Model side of the handshakes, evaluated at each active edge.
   initial forever begin
      logic        p_vld;
      logic        p_rdy;
      logic [31:0] r;
      int          l;
      @(posedge clk);
      if (!rst_n) begin
         q.delete();
      end else begin
         p_vld = (q.size() != 0) && (cyc >= q[0].due);
         p_rdy = (q.size() == 0) || (p_vld && result_rdy);
         if (p_vld && result_rdy) begin
            last_res = q[0].res;
            last_tag = q[0].tag;
            last_lat = q[0].lat;
            pops++;
            void'(q.pop_front());
         end
         if (op_kill) q.delete();
         if (op_vld && (p_rdy || op_kill)) begin
            model(op, op_a, op_b, r, l);
            q.push_back('{res: r, tag: op_tag, due: cyc + 1 + l, lat: l});
         end
      end
      cyc = cyc + 1;
   end

   // Compare DUT outputs with the model every cycle.
   initial forever begin
      logic n_vld;
      logic n_rdy;
      @(negedge clk);
      if (rst_n) begin
         n_vld = (q.size() != 0) && (cyc >= q[0].due);
         n_rdy = (q.size() == 0) || (n_vld && result_rdy);
         chk("result_vld", {31'b0, result_vld}, {31'b0, n_vld});
         chk("op_rdy", {31'b0, op_rdy}, {31'b0, n_rdy});
         if (n_vld && result_vld) begin
            chk("result", result, q[0].res);
            chk("result_tag", {27'b0, result_tag}, {27'b0, q[0].tag});
            if (result_rdy) last_dut = result;
         end
      end
   end

   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
      @(posedge clk); #1;
      op = o; op_a = a; op_b = b; op_tag = t; op_vld = 1'b1;
      @(posedge clk); #1;
      op_vld = 1'b0;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL %s timeout: %0d results still pending, required 0", name, q.size());
      end
   endtask

   task automatic wait_vld(input string name);
      int n;
      n = 0;
      while (!result_vld && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (!result_vld) begin
         errors++;
         $display("FAIL %s timeout: result_vld %0b, required 1", name, result_vld);
      end
   endtask

   task automatic run(input string name, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] t, input logic [31:0] exp_r, input int exp_lat);
      issue(o, a, b, t);
      drain(name);
      chk({name, " model"}, last_res, exp_r);
      chk({name, " dut"}, last_dut, exp_r);
      chk({name, " latency"}, last_lat, exp_lat);
      chk({name, " tag"}, {27'b0, last_tag}, {27'b0, t});
   endtask

   initial begin
      int p0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("reset op_rdy", {31'b0, op_rdy}, 32'd1);
      chk("reset result_vld", {31'b0, result_vld}, 32'd0);
      chk("reset result", result, 32'h0);
      chk("reset result_tag", {27'b0, result_tag}, 32'h0);

      run("div neg", 3'd4, 32'hFFFFFFF9, 32'h2, 5'h01, 32'hFFFFFFFD, EE ? 5 : 34);
      run("rem neg", 3'd6, 32'hFFFFFFF9, 32'h2, 5'h02, 32'hFFFFFFFF, EE ? 5 : 34);
      run("divu by0", 3'd5, 32'h12345678, 32'h0, 5'h03, 32'hFFFFFFFF, EE ? 31 : 34);
      run("rem by0", 3'd6, 32'h12345678, 32'h0, 5'h04, 32'h12345678, EE ? 31 : 34);
      run("div ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 5'h05, 32'h80000000, 34);
      run("rem ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 5'h06, 32'h0, 34);
      run("div neg by0", 3'd4, 32'hFFFFFFF9, 32'h0, 5'h07, 32'hFFFFFFFF, EE ? 5 : 34);
      run("rem neg by0", 3'd6, 32'hFFFFFFF9, 32'h0, 5'h08, 32'hFFFFFFF9, EE ? 5 : 34);
      run("mulhsu", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'h09, 32'hFFFFFFFF, 34);
      run("mul", 3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'h0A, 32'h00000001, 34);
      run("mulhu", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'h0B, 32'hFFFFFFFE, 34);
      run("mulh carry", 3'd1, 32'hFFFFFFFF, 32'h0, 5'h0C, 32'h0, 35);
      run("mulh neg", 3'd1, 32'hFFFFFFFD, 32'h5, 5'h0D, 32'hFFFFFFFF, 34);
      run("mulh minmin", 3'd1, 32'h80000000, 32'h80000000, 5'h0E, 32'h40000000, 34);
      run("divu zero", 3'd5, 32'h0, 32'h3, 5'h0F, 32'h0, EE ? 2 : 34);
      run("divu 5/3", 3'd5, 32'h5, 32'h3, 5'h10, 32'h1, EE ? 5 : 34);
      run("remu 5/3", 3'd7, 32'h5, 32'h3, 5'h11, 32'h2, EE ? 5 : 34);

      // Backpressure, then issue in the same cycle the result is consumed.
      result_rdy = 1'b0;
      issue(3'd0, 32'd3, 32'd5, 5'h11);
      wait_vld("bp vld");
      repeat (5) begin
         @(negedge clk);
         chk("bp result", result, 32'd15);
         chk("bp tag", {27'b0, result_tag}, 32'h11);
         chk("bp op_rdy", {31'b0, op_rdy}, 32'd0);
      end
      @(posedge clk); #1;
      result_rdy = 1'b1;
      op = 3'd5; op_a = 32'd100; op_b = 32'd7; op_tag = 5'h12; op_vld = 1'b1;
      @(negedge clk);
      chk("bp op_rdy consume", {31'b0, op_rdy}, 32'd1);
      @(posedge clk); #1;
      op_vld = 1'b0;
      @(negedge clk);
      chk("bp reissue busy", {31'b0, op_rdy}, 32'd0);
      drain("bp reissue");
      chk("bp reissue dut", last_dut, 32'd14);
      chk("bp reissue tag", {27'b0, last_tag}, 32'h12);

      // Kill a running divide with a new one.
      issue(3'd4, 32'd1000, 32'd3, 5'h03);
      p0 = pops;
      repeat (10) @(posedge clk);
      #1;
      op_kill = 1'b1; op_vld = 1'b1; op = 3'd5; op_a = 32'd100; op_b = 32'd7; op_tag = 5'h1A;
      @(posedge clk); #1;
      op_kill = 1'b0; op_vld = 1'b0;
      drain("kill");
      chk("kill dut", last_dut, 32'd14);
      chk("kill tag", {27'b0, last_tag}, 32'h1A);
      chk("kill latency", last_lat, EE ? 9 : 34);
      chk("kill pops", pops - p0, 32'd1);

      // Kill drops a held result.
      result_rdy = 1'b0;
      issue(3'd0, 32'd7, 32'd6, 5'h05);
      wait_vld("kill done vld");
      p0 = pops;
      @(posedge clk); #1 op_kill = 1'b1;
      @(posedge clk); #1 op_kill = 1'b0;
      @(negedge clk);
      chk("kill done vld", {31'b0, result_vld}, 32'd0);
      result_rdy = 1'b1;
      repeat (3) @(negedge clk);
      chk("kill done pops", pops - p0, 32'd0);

      // Requests while busy are ignored.
      issue(3'd3, 32'h00010000, 32'h00010000, 5'h06);
      @(posedge clk); #1;
      op = 3'd0; op_a = 32'd2; op_b = 32'd2; op_tag = 5'h07; op_vld = 1'b1;
      repeat (3) @(posedge clk);
      #1 op_vld = 1'b0;
      drain("busy");
      chk("busy result", last_dut, 32'h1);
      chk("busy tag", {27'b0, last_tag}, 32'h06);

      // Asynchronous reset mid-operation.
      issue(3'd0, 32'h1234, 32'h5678, 5'h09);
      repeat (5) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("areset result_vld", {31'b0, result_vld}, 32'd0);
      chk("areset op_rdy", {31'b0, op_rdy}, 32'd1);
      chk("areset result", result, 32'h0);
      chk("areset tag", {27'b0, result_tag}, 32'h0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      run("after reset", 3'd0, 32'h00010001, 32'h00010001, 5'h09, 32'h00020001, 34);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
